param_computational_unit: RTL
=============================

Name: param_computational_unit

Overview:
- Next-generation datapath of the team's small microcontroller.
- Parametrised data width and x/y register-bank depth.
- Adds carry flag, a shift-left op, and an iterative shift-add multiplier (full 2*DW product into r_hi:r) with busy handshake.
- Sits between the program sequencer/instruction decoder and data memory/IO pins; drives data_bus, o_reg, i (address) and flags back to the sequencer.

Parameters:
DW, 8, data width of all registers and buses (>=2)
NX, 2, number of x registers (>=1)
NY, 2, number of y registers (>=1)
XSW, max(1,clog2(NX)), x_sel width (derived)
YSW, max(1,clog2(NY)), y_sel width (derived)
SSW, clog2(NX+NY+7), source_sel width (derived)
REW, NX+NY+4, reg_en width (derived)

Ports:
clk  in  1  system clock, all state on rising edge
async_reset_n  in  1  asynchronous active-low reset
sync_reset  in  1  synchronous clear of r, r_hi, flags, multiplier
ir_op  in  4  ALU opcode: [2:0] function, [3] nop qualifier
pm_data  in  DW  immediate from program memory
dm  in  DW  data memory read data
i_pins  in  DW  input pins
source_sel  in  SSW  data_bus source
x_sel  in  XSW  ALU x operand select
y_sel  in  YSW  ALU y operand select
i_sel  in  1  0: i<=data_bus, 1: i<=i+m
reg_en  in  REW  [NX-1:0] x regs, [NX+NY-1:NX] y regs, then r, m, i, o_reg
data_bus  out  DW  muxed bus
o_reg  out  DW  output register
i  out  DW  index/address register
r  out  DW  result (low)
r_hi  out  DW  product high half
r_eq_0  out  1  zero flag
carry  out  1  carry/borrow flag
busy  out  1  multiplier running

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on async_reset_n. The polarity and synchronicity are fixed.
- async_reset_n low: all registers and outputs 0, except r_eq_0=1. busy=0, FSM=IDLE.
- data_bus, combinational, by source_sel:
  - 0..NX-1: x[k]; NX..NX+NY-1: y[k].
  - Then in order: r, r_hi, m, i, dm, pm_data, i_pins.
  - Out of range: 0.
- x, y, m, i, o_reg: load on rising edge when their reg_en bit is set, else hold.
- i with i_sel=1: i<=i+m, modulo 2^DW.
- ALU applies only when reg_en[r]=1, busy=0 and sync_reset=0. Single-cycle results load into r on that edge. r_eq_0<=(result==0). r_hi holds.
  - 0 (bit3=0): -x; carry<=(x!=0).
  - 1: x-y; carry<=borrow (x<y).
  - 2: x+y; carry<=carry-out.
  - 3: start multiply; see below.
  - 4: x<<1; carry<=x[DW-1].
  - 5: x^y; 6: x&y; carry unchanged.
  - 7 (bit3=0): ~x; carry unchanged.
  - ir_op 8 or 15: nop; r, r_hi and flags hold.
  - For ops 1..6, bit3 is ignored.
- Multiplier FSM, states IDLE/MUL, counter 0..DW-1:
  - Start: op 3 accepted on edge k. Operands x,y are captured, accumulator cleared, busy=1 after edge k.
  - Each MUL cycle does one shift-add step.
  - On edge k+DW: {r_hi,r}<=x*y (unsigned), r_eq_0<=(product==0), carry<=0, busy=0, FSM=IDLE.
  - Latency is DW cycles. A new op may be issued the cycle busy reads 0.
  - While busy: reg_en[r] is ignored and ALU ops are discarded. Other registers stay writable. Captured operands are unaffected by x/y writes.
- sync_reset=1, highest priority synchronous:
  - r=0, r_hi=0, r_eq_0=1, carry=0, busy=0, FSM=IDLE. Aborts any multiply.
  - Other registers obey reg_en normally.
- Arithmetic wraps modulo 2^DW. No saturation.

Decomposition:
- Package param_cu_pkg holds:
  - opcode constants OP_NEG..OP_NOT, OP_NOP0=4'h8, OP_NOP7=4'hF;
  - source_sel offset function of NX,NY;
  - FSM state enum {IDLE, MUL}.
- One sub-module, cu_seq_mult: parametrised DW shift-add multiplier. Interface: start, a, b, busy, done, product[2*DW-1:0]; async reset; sync abort.

Test Plan:
- DW=8, NX=NY=2. Drop async_reset_n mid-cycle -> immediately all regs 0, r_eq_0=1, busy=0.
- Load x0=0xFF, y0=0x01 via pm_data; issue op 2 -> r=0x00, carry=1, r_eq_0=1. Then op 1 with x=0x01, y=0x02 -> r=0xFF, carry=1, r_eq_0=0.
- Load x1=0x0F, y1=0x11; issue op 3 with x_sel=1, y_sel=1 -> busy high exactly 8 cycles, then r_hi=0x00, r=0xFF. An op-2 pulse at cycle 3 of busy is ignored; an x1 write at cycle 2 does not alter the product.
- Op 3 with 0xFF*0xFF -> r_hi=0xFE, r=0x01. Repeat with sync_reset asserted at cycle 4 -> next edge busy=0, r=0, r_hi=0, r_eq_0=1.
- ir_op 8 and 15 with reg_en[r]=1 -> r, carry, r_eq_0 unchanged. Op 0 with x=0 -> r=0, r_eq_0=1, carry=0.
- m=0x30, i=0xF0, i_sel=1 -> i=0x20. source_sel=13 (out of range) -> data_bus=0x00.

Source files
------------

// File: rtl/param_cu_pkg.sv
// Shared definitions for the parametrised computational unit.
//   - ALU opcode encodings (ir_op[2:0] selects the function, ir_op[3] only
//     matters for the two nop codes 4'h8 and 4'hF)
//   - data_bus source slots that follow the x/y register banks, plus a helper
//     that turns a slot into an absolute source_sel value for a given NX/NY
//   - multiplier FSM state encoding
package param_cu_pkg;

   localparam logic [3:0] OP_NEG  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_MUL  = 4'h3;
   localparam logic [3:0] OP_SHL  = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_AND  = 4'h6;
   localparam logic [3:0] OP_NOT  = 4'h7;
   localparam logic [3:0] OP_NOP0 = 4'h8;
   localparam logic [3:0] OP_NOP7 = 4'hF;

   // Bus slots after the x and y banks, in bus order.
   localparam int SRC_R     = 0;
   localparam int SRC_R_HI  = 1;
   localparam int SRC_M     = 2;
   localparam int SRC_I     = 3;
   localparam int SRC_DM    = 4;
   localparam int SRC_PM    = 5;
   localparam int SRC_PINS  = 6;
   localparam int SRC_COUNT = 7;

   // Absolute source_sel value of a fixed slot: the x and y banks come first.
   function automatic int src_sel_of(input int nx, input int ny, input int slot);
      return nx + ny + slot;
   endfunction

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } mult_state_e;

endpackage

// File: rtl/param_computational_unit_mult.sv
// cu_seq_mult: iterative unsigned shift-add multiplier, one partial product
// per clock.
//
// Ports
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset
//   abort_i    synchronous abort, returns to IDLE and drops the operation
//   start_i    accepted only in IDLE; captures a_i/b_i on that edge
//   a_i, b_i   operands (DW bits each)
//   busy_o     high from the edge after start until the result edge
//   done_o     combinational, high during the last MUL cycle; product_o is
//              valid while done_o is high and is meant to be registered on
//              that same edge
//   product_o  full 2*DW-bit product
//   state_o    FSM state (IDLE=0, MUL=1) for debug visibility
//
// Handshake: start_i is a single-cycle request that is only honoured while
// busy_o is low; a start seen while busy_o is high is ignored. done_o pulses
// for exactly one cycle, DW cycles after the accepting edge, unless abort_i
// cancels the operation first.
module cu_seq_mult
   import param_cu_pkg::*;
#(
   parameter  int DW = 8,
   localparam int CW = (DW > 1) ? $clog2(DW) : 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              abort_i,
   input  logic              start_i,
   input  logic [DW-1:0]     a_i,
   input  logic [DW-1:0]     b_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [2*DW-1:0]   product_o,
   output logic              state_o
);

   mult_state_e       state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DW-1:0]     mcand_q, mcand_d;
   // {high half, multiplier bits}: the low half starts as the multiplier and
   // is shifted out one bit per step while product bits shift in from above.
   logic [2*DW-1:0]   acc_q, acc_d;
   logic [DW:0]       partial;
   logic [2*DW-1:0]   acc_step;

   always_comb begin
      partial  = {1'b0, acc_q[2*DW-1:DW]}
               + (acc_q[0] ? {1'b0, mcand_q} : {(DW+1){1'b0}});
      acc_step = {partial, acc_q[DW-1:1]};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      done_o  = 1'b0;
      if (abort_i) begin
         state_d = IDLE;
         cnt_d   = '0;
         mcand_d = '0;
         acc_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_d = MUL;
                  cnt_d   = '0;
                  mcand_d = a_i;
                  acc_d   = {{DW{1'b0}}, b_i};
               end
            end
            MUL: begin
               acc_d = acc_step;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(DW-1)) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  done_o  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mcand_q <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
      end
   end

   // The final step is presented combinationally so the caller can load the
   // result on the same edge the FSM returns to IDLE.
   assign product_o = acc_step;
   assign busy_o    = (state_q == MUL);
   assign state_o   = state_q;

endmodule

// File: rtl/param_computational_unit.sv
// param_computational_unit: datapath of the small microcontroller.
// Holds NX x-registers, NY y-registers, result r (and r_hi for products),
// m and i (index/address) registers and an output register, all fed from a
// single muxed data_bus. A single-cycle ALU writes r and the flags; opcode 3
// launches a DW-cycle shift-add multiply that returns {r_hi, r}.
//
// Ports
//   clk, async_reset_n   clock / asynchronous active-low reset
//   sync_reset           synchronous clear of r, r_hi, flags, multiplier
//   ir_op                ALU opcode ([2:0] function, [3] nop qualifier)
//   pm_data, dm, i_pins  external bus sources
//   source_sel           data_bus source (x bank, y bank, r, r_hi, m, i,
//                        dm, pm_data, i_pins; anything else reads 0)
//   x_sel, y_sel         ALU operand selects
//   i_sel                0: i <= data_bus, 1: i <= i + m
//   reg_en               per-register write enables: x bank, y bank, r, m,
//                        i, o_reg (LSB first)
//   data_bus, o_reg, i, r, r_hi, r_eq_0, carry, busy   datapath outputs
//   dbg_mult_state       multiplier FSM state (0 = IDLE, 1 = MUL)
//
// Handshake: busy is high while a multiply is in flight. During that time
// reg_en[r] is ignored and ALU opcodes are discarded; every other register
// remains writable. A new opcode may be issued in the cycle busy reads 0.
module param_computational_unit
   import param_cu_pkg::*;
#(
   parameter  int DW  = 8,
   parameter  int NX  = 2,
   parameter  int NY  = 2,
   localparam int XSW = (NX > 1) ? $clog2(NX) : 1,
   localparam int YSW = (NY > 1) ? $clog2(NY) : 1,
   localparam int SSW = $clog2(NX + NY + SRC_COUNT),
   localparam int REW = NX + NY + 4
) (
   input  logic            clk,
   input  logic            async_reset_n,
   input  logic            sync_reset,
   input  logic [3:0]      ir_op,
   input  logic [DW-1:0]   pm_data,
   input  logic [DW-1:0]   dm,
   input  logic [DW-1:0]   i_pins,
   input  logic [SSW-1:0]  source_sel,
   input  logic [XSW-1:0]  x_sel,
   input  logic [YSW-1:0]  y_sel,
   input  logic            i_sel,
   input  logic [REW-1:0]  reg_en,
   output logic [DW-1:0]   data_bus,
   output logic [DW-1:0]   o_reg,
   output logic [DW-1:0]   i,
   output logic [DW-1:0]   r,
   output logic [DW-1:0]   r_hi,
   output logic            r_eq_0,
   output logic            carry,
   output logic            busy,
   output logic            dbg_mult_state
);

   // reg_en bit positions of the single registers.
   localparam int EN_R = NX + NY;
   localparam int EN_M = NX + NY + 1;
   localparam int EN_I = NX + NY + 2;
   localparam int EN_O = NX + NY + 3;

   // Absolute source_sel codes of the fixed bus slots.
   localparam logic [SSW-1:0] SEL_R    = SSW'(src_sel_of(NX, NY, SRC_R));
   localparam logic [SSW-1:0] SEL_R_HI = SSW'(src_sel_of(NX, NY, SRC_R_HI));
   localparam logic [SSW-1:0] SEL_M    = SSW'(src_sel_of(NX, NY, SRC_M));
   localparam logic [SSW-1:0] SEL_I    = SSW'(src_sel_of(NX, NY, SRC_I));
   localparam logic [SSW-1:0] SEL_DM   = SSW'(src_sel_of(NX, NY, SRC_DM));
   localparam logic [SSW-1:0] SEL_PM   = SSW'(src_sel_of(NX, NY, SRC_PM));
   localparam logic [SSW-1:0] SEL_PINS = SSW'(src_sel_of(NX, NY, SRC_PINS));

   logic [DW-1:0] x_q [NX];
   logic [DW-1:0] y_q [NY];
   logic [DW-1:0] r_q, r_d;
   logic [DW-1:0] r_hi_q, r_hi_d;
   logic [DW-1:0] m_q, m_d;
   logic [DW-1:0] i_q, i_d;
   logic [DW-1:0] o_q, o_d;
   logic          eq_q, eq_d;
   logic          carry_q, carry_d;

   logic [DW-1:0]   x_op, y_op;
   logic [DW-1:0]   alu_res;
   logic            alu_carry;
   logic [DW:0]     alu_sum;
   logic            is_nop;
   logic            alu_go;
   logic            mul_start;
   logic            mul_busy;
   logic            mul_done;
   logic [2*DW-1:0] mul_product;
   logic            mul_state;

   // ---------------------------------------------------------------- bus mux
   always_comb begin
      data_bus = '0;
      for (int k = 0; k < NX; k++) begin
         if (source_sel == SSW'(k)) data_bus = x_q[k];
      end
      for (int k = 0; k < NY; k++) begin
         if (source_sel == SSW'(NX + k)) data_bus = y_q[k];
      end
      if (source_sel == SEL_R)    data_bus = r_q;
      if (source_sel == SEL_R_HI) data_bus = r_hi_q;
      if (source_sel == SEL_M)    data_bus = m_q;
      if (source_sel == SEL_I)    data_bus = i_q;
      if (source_sel == SEL_DM)   data_bus = dm;
      if (source_sel == SEL_PM)   data_bus = pm_data;
      if (source_sel == SEL_PINS) data_bus = i_pins;
   end

   // ------------------------------------------------------- operand selects
   always_comb begin
      x_op = x_q[0];
      for (int k = 0; k < NX; k++) begin
         if (x_sel == XSW'(k)) x_op = x_q[k];
      end
      y_op = y_q[0];
      for (int k = 0; k < NY; k++) begin
         if (y_sel == YSW'(k)) y_op = y_q[k];
      end
   end

   // -------------------------------------------------------------------- ALU
   // Only 4'h8 and 4'hF are nops; every other code decodes on ir_op[2:0].
   assign is_nop    = (ir_op == OP_NOP0) || (ir_op == OP_NOP7);
   assign alu_go    = reg_en[EN_R] && !mul_busy && !sync_reset && !is_nop;
   assign mul_start = alu_go && (ir_op[2:0] == OP_MUL[2:0]);

   always_comb begin
      alu_sum   = {1'b0, x_op} + {1'b0, y_op};
      alu_res   = r_q;
      alu_carry = carry_q;
      case (ir_op[2:0])
         OP_NEG[2:0]: begin
            alu_res   = -x_op;
            alu_carry = (x_op != '0);
         end
         OP_SUB[2:0]: begin
            alu_res   = x_op - y_op;
            alu_carry = (x_op < y_op);
         end
         OP_ADD[2:0]: begin
            alu_res   = alu_sum[DW-1:0];
            alu_carry = alu_sum[DW];
         end
         OP_SHL[2:0]: begin
            alu_res   = {x_op[DW-2:0], 1'b0};
            alu_carry = x_op[DW-1];
         end
         OP_XOR[2:0]: alu_res = x_op ^ y_op;
         OP_AND[2:0]: alu_res = x_op & y_op;
         OP_NOT[2:0]: alu_res = ~x_op;
         default:     alu_res = r_q;
      endcase
   end

   // ------------------------------------------------------------- multiplier
   cu_seq_mult #(
      .DW (DW)
   ) u_mult (
      .clk_i     (clk),
      .rst_ni    (async_reset_n),
      .abort_i   (sync_reset),
      .start_i   (mul_start),
      .a_i       (x_op),
      .b_i       (y_op),
      .busy_o    (mul_busy),
      .done_o    (mul_done),
      .product_o (mul_product),
      .state_o   (mul_state)
   );

   // --------------------------------------------------------- next state
   always_comb begin
      r_d     = r_q;
      r_hi_d  = r_hi_q;
      eq_d    = eq_q;
      carry_d = carry_q;
      if (sync_reset) begin
         r_d     = '0;
         r_hi_d  = '0;
         eq_d    = 1'b1;
         carry_d = 1'b0;
      end else if (mul_done) begin
         r_hi_d  = mul_product[2*DW-1:DW];
         r_d     = mul_product[DW-1:0];
         eq_d    = (mul_product == '0);
         carry_d = 1'b0;
      end else if (alu_go && !mul_start) begin
         r_d     = alu_res;
         eq_d    = (alu_res == '0);
         carry_d = alu_carry;
      end

      m_d = reg_en[EN_M] ? data_bus : m_q;
      o_d = reg_en[EN_O] ? data_bus : o_q;
      i_d = i_q;
      if (reg_en[EN_I]) begin
         i_d = i_sel ? (i_q + m_q) : data_bus;
      end
   end

   // -------------------------------------------------------------- registers
   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
         for (int k = 0; k < NX; k++) x_q[k] <= '0;
         for (int k = 0; k < NY; k++) y_q[k] <= '0;
      end else begin
         for (int k = 0; k < NX; k++) begin
            if (reg_en[k]) x_q[k] <= data_bus;
         end
         for (int k = 0; k < NY; k++) begin
            if (reg_en[NX + k]) y_q[k] <= data_bus;
         end
      end
   end

   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
         r_q     <= '0;
         r_hi_q  <= '0;
         m_q     <= '0;
         i_q     <= '0;
         o_q     <= '0;
         eq_q    <= 1'b1;
         carry_q <= 1'b0;
      end else begin
         r_q     <= r_d;
         r_hi_q  <= r_hi_d;
         m_q     <= m_d;
         i_q     <= i_d;
         o_q     <= o_d;
         eq_q    <= eq_d;
         carry_q <= carry_d;
      end
   end

   assign o_reg          = o_q;
   assign i              = i_q;
   assign r              = r_q;
   assign r_hi           = r_hi_q;
   assign r_eq_0         = eq_q;
   assign carry          = carry_q;
   assign busy           = mul_busy;
   assign dbg_mult_state = mul_state;

endmodule
